// File: rtl/axi_rd_responder.sv
// -----------------------------------------------------------------------------
// axi_rd_responder
//   AXI4 read-channel responder (slave) in the m_clk domain. Serves AR requests
//   from an internal word-addressed memory and returns R bursts, one beat per
//   cycle while rready is high. A backdoor write port loads the memory, which
//   is not cleared by reset.
//
//   Optional feature macro: AXI_RD_RESPONDER_WRAP_EN
//     defined   : WRAP bursts (len 1/3/7/15) are served.
//     undefined : wrap logic is not built; burst = 2 returns SLVERR beats.
//
// Ports
//   m_clk, s_rst          clock; synchronous active-high reset
//   s_axi_ar*             read request channel (lock/cache/prot/qos/region/user
//                         are accepted and ignored)
//   s_axi_r*              read data channel (ruser driven to 0)
//   mem_wr_en/addr/data   backdoor memory write port
// -----------------------------------------------------------------------------
module axi_rd_responder #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned ARUSER_WIDTH = 1,
    parameter int unsigned RUSER_WIDTH  = 1,
    parameter int unsigned MEM_DEPTH    = 256
) (
    input  logic                          m_clk,
    input  logic                          s_rst,
    input  logic [ID_WIDTH-1:0]           s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arlock,
    input  logic [3:0]                    s_axi_arcache,
    input  logic [2:0]                    s_axi_arprot,
    input  logic [3:0]                    s_axi_arqos,
    input  logic [3:0]                    s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0]       s_axi_aruser,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [ID_WIDTH-1:0]           s_axi_rid,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]        s_axi_ruser,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic                          mem_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]         mem_wr_data
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned SH    = $clog2(BYTES);
    localparam int unsigned MAW   = $clog2(MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
`ifdef AXI_RD_RESPONDER_WRAP_EN
    localparam logic [1:0] BURST_WRAP  = 2'd2;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Latched request context
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_slverr;
    logic [7:0]            r_cnt;

    // R channel output registers
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_ar_slverr;
    logic                  w_load;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] w_incr_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
`ifdef AXI_RD_RESPONDER_WRAP_EN
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
`endif
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic                  w_beat_err;
    logic [7:0]            w_beat_len;
    logic [7:0]            w_beat_cnt;
    logic                  w_beat_in_range;
    logic [DATA_WIDTH-1:0] w_beat_word;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic [1:0]            w_beat_resp;
    logic                  w_unused;

    assign w_unused = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot,
                        s_axi_arqos, s_axi_arregion, s_axi_aruser};

    // arready is held low while reset is asserted, even in IDLE
    assign s_axi_arready = (r_state == ST_IDLE) && !s_rst;
    assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_r_hs        = r_rvalid && s_axi_rready;

    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_ruser   = '0;

    // Burst-wide SLVERR classification of the incoming request
    always_comb begin : ar_check
        w_ar_slverr = (32'(s_axi_arsize) > SH);
        case (s_axi_arburst)
            BURST_FIXED, BURST_INCR: ;
`ifdef AXI_RD_RESPONDER_WRAP_EN
            BURST_WRAP: begin
                if (!(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
                    w_ar_slverr = 1'b1;
                end
            end
`endif
            default: w_ar_slverr = 1'b1;
        endcase
    end

    // Address of the beat following the current one
    always_comb begin : next_addr
        w_incr_addr = r_addr + (ADDR_WIDTH'(1) << r_size);
`ifdef AXI_RD_RESPONDER_WRAP_EN
        // Window is (len+1) << size bytes; a power of two for every legal wrap len
        w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
`endif
        case (r_burst)
            BURST_FIXED: w_next_addr = r_addr;
`ifdef AXI_RD_RESPONDER_WRAP_EN
            BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
`endif
            default:     w_next_addr = w_incr_addr;
        endcase
    end

    // Next-state and beat-load decisions
    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = ST_BURST;
                    w_load      = 1'b1;
                end
            end
            ST_BURST: begin
                if (w_r_hs) begin
                    if (r_rlast) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Beat 0 comes straight from AR; later beats from the latched context
    always_comb begin : beat_sel
        if (r_state == ST_IDLE) begin
            w_beat_addr = s_axi_araddr;
            w_beat_err  = w_ar_slverr;
            w_beat_len  = s_axi_arlen;
            w_beat_cnt  = 8'd0;
        end else begin
            w_beat_addr = w_next_addr;
            w_beat_err  = r_slverr;
            w_beat_len  = r_len;
            w_beat_cnt  = r_cnt + 8'd1;
        end
        w_beat_in_range = (64'(w_beat_addr >> SH) < 64'(MEM_DEPTH));
        w_beat_word     = r_mem[MAW'(w_beat_addr >> SH)];
        if (w_beat_err) begin
            w_beat_resp = RESP_SLVERR;
            w_beat_data = '0;
        end else if (!w_beat_in_range) begin
            w_beat_resp = RESP_DECERR;
            w_beat_data = '0;
        end else begin
            w_beat_resp = RESP_OKAY;
            w_beat_data = w_beat_word;
        end
    end

    // State register
    always_ff @(posedge m_clk) begin : state_reg
        if (s_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request context and R channel registers
    always_ff @(posedge m_clk) begin : r_channel
        if (s_rst) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_slverr <= 1'b0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rid    <= s_axi_arid;
                r_len    <= s_axi_arlen;
                r_size   <= s_axi_arsize;
                r_burst  <= s_axi_arburst;
                r_slverr <= w_ar_slverr;
            end
            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rlast  <= (w_beat_cnt == w_beat_len);
                r_rdata  <= w_beat_data;
                r_rresp  <= w_beat_resp;
                r_cnt    <= w_beat_cnt;
                r_addr   <= w_beat_addr;
            end else if (w_done) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    // Backdoor write; a same-cycle beat load reads the old word
    always_ff @(posedge m_clk) begin : mem_write
        if (mem_wr_en) begin
            r_mem[mem_wr_addr] <= mem_wr_data;
        end
    end

endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

AXI4 read-channel responder (slave) clocked on the master-side clock domain, serving AR requests from an internal word-addressed memory and returning R bursts. It is the far-end counterpart of the read-channel CDC bridge: it terminates the bridge's initiator AR/R port in the bridge test harness and in template apps that need a local read-only table. A backdoor write port loads memory contents.

## Interface
- DATA_WIDTH, 64, R data width in bits; power of two, 8 to 512.
- ADDR_WIDTH, 16, byte address width.
- ID_WIDTH, 8, AXI ID width.
- ARUSER_WIDTH, 1, AR user width; accepted and ignored.
- RUSER_WIDTH, 1, R user width; driven to 0.
- MEM_DEPTH, 256, memory depth in DATA_WIDTH words.
- Reset is s_rst, synchronous, active-high. The clock is m_clk.
- m_clk  in  1  sole clock; every register updates on its rising edge.
- s_rst  in  1  synchronous active-high reset.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read request fields.
- s_axi_arlock/arcache/arprot/arqos/arregion/aruser  in  1/4/3/4/4/ARUSER_WIDTH  accepted, ignored.
- s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rid  out  ID_WIDTH;  s_axi_rdata  out  DATA_WIDTH;  s_axi_rresp  out  2;  s_axi_rlast  out  1;  s_axi_ruser  out  RUSER_WIDTH.
- s_axi_rvalid  out  1;  s_axi_rready  in  1.
- mem_wr_en  in  1  backdoor write strobe.
- mem_wr_addr  in  $clog2(MEM_DEPTH)  backdoor word index.
- mem_wr_data  in  DATA_WIDTH  backdoor write data.

## Operation
- Let BYTES = DATA_WIDTH/8 and SH = log2(BYTES). The word index is addr >> SH.
- IDLE state:
  - arready = 1.
  - On arvalid && arready, latch id, addr, len, size and burst, then go to BURST.
  - Beat 0 is loaded into the R registers on the same edge.
- BURST state:
  - arready = 0 and rvalid = 1.
  - On rvalid && rready with rlast = 0, load the next beat on the same edge.
  - On rvalid && rready with rlast = 1, clear rvalid and go to IDLE.
- Beat count: a counter runs from 0 to len; rlast = (count == len).
- Next-beat address, applied after each beat:
  - FIXED (0): unchanged.
  - INCR (1): addr + (1 << size), ADDR_WIDTH modulo.
  - WRAP (2): the byte address wraps within an aligned window of (len+1) << size bytes.
- Beat data: rdata is the full word at the word index. There is no lane shifting for narrow sizes.
- Beat response, in priority order:
  - SLVERR (2) if size > SH, burst = 3, or the burst is WRAP with len not in {1,3,7,15}. SLVERR applies to every beat of that burst.
  - Otherwise DECERR (3) for a beat whose word index >= MEM_DEPTH.
  - Otherwise OKAY (0).
  - rdata = 0 on any error beat.
- Error bursts still return exactly len+1 beats with a correct rlast.
- rid = latched arid on every beat. ruser = 0.
- Backdoor port: when mem_wr_en = 1, mem[mem_wr_addr] <= mem_wr_data. A write and a beat load to the same word in the same cycle: the beat carries the old data. The memory is not cleared by reset.

## Timing
- Reset values: arready 0 during the reset cycle, then 1. rvalid 0, rlast 0, rid 0, rdata 0, rresp 0, ruser 0. State = IDLE, counter 0.
- Latency: AR handshake at edge t gives rvalid = 1 with beat 0 from edge t (visible in cycle t+1).
- Throughput: one beat per cycle while rready = 1.
- One idle cycle after each rlast handshake before arready reasserts. Peak rate is (len+1)/(len+2).
- R outputs hold stable while rvalid && !rready.
- s_rst asserted mid-burst: the burst is abandoned, rvalid drops at that edge, no further beats are issued, and IDLE is entered.
- arvalid asserted during BURST is not accepted until IDLE.

## Configuration
- AXI_RD_RESPONDER_WRAP_EN defined: WRAP bursts are supported as specified above.
- AXI_RD_RESPONDER_WRAP_EN undefined: the wrap logic is not built, and burst = 2 is treated like burst = 3, i.e. all beats return SLVERR with rdata 0.

## Test plan
All scenarios use DATA_WIDTH=64 and MEM_DEPTH=256, with mem[i] = i backdoor-loaded.
- INCR: araddr=0x40, arlen=3, arsize=3, rready=1 -> rdata 8,9,10,11; rresp 0; rlast only on beat 3; rvalid one cycle after the handshake; rid echoed.
- Backpressure: same burst with rready toggling 1,0,0,1,... -> no beat lost or duplicated; outputs stable while stalled.
- WRAP: araddr=0x30, arlen=3, arsize=3 -> rdata 6,7,4,5. With the macro undefined -> 4 beats of SLVERR, rdata 0.
- Errors:
  - arsize=4 -> arlen+1 beats of rresp 2.
  - INCR araddr=0x7F8, arlen=1 -> beat 0 returns 255 OKAY; beat 1 returns DECERR with rdata 0.
- FIXED arlen=2 at 0x10 -> 2,2,2. Back-to-back AR requests -> arready low during the burst, exactly one idle cycle between bursts.
- s_rst pulsed after beat 1 of an arlen=7 burst -> rvalid 0 next cycle; arready 1 after reset; a new request is served correctly.
